sync_fifo_rr_write_arbiter: RTL and testbench

- Shares the single write port of one synchronous FIFO buffer among NUM_REQ producers.
- Uses round-robin arbitration with burst locking: a granted producer keeps the port for up to MAX_BURST words or until it signals last.
- Each word is written with the producer ID as a tag, so the consumer can demultiplex.
- Sits between producer valid/ready interfaces and the FIFO's write_i / wr_data_i / full_o pins.

---
 rtl/sync_fifo_rr_write_arbiter.sv | 129 ++++++++++++
 tb/tb_sync_fifo_rr_write_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_rr_write_arbiter.sv
// Round-robin, burst-locking arbiter sharing one synchronous FIFO write port among producers.
// Each accepted word is tagged with the producer index so the consumer can demultiplex.
module sync_fifo_rr_write_arbiter #(
    parameter int unsigned  NUM_REQ    = 4,
    parameter int unsigned  DATA_WIDTH = 32,
    parameter int unsigned  MAX_BURST  = 8,
    localparam int unsigned TAG_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic                          fifo_full_i,
    output logic                          fifo_write_o,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data_o,
    output logic [TAG_W-1:0]              fifo_wr_tag_o,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic                          busy_o
);

    localparam int unsigned CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    typedef enum logic {StIdle, StGrant} state_e;

    state_e             state_q, state_d;
    logic [TAG_W-1:0]   owner_q, owner_d;
    logic [TAG_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;

    logic [DATA_WIDTH-1:0] lane_data [NUM_REQ];
    logic [TAG_W-1:0]      pick;
    logic                  pick_found;
    logic [TAG_W:0]        scan_idx;
    logic [TAG_W-1:0]      owner_next_ptr;
    logic                  in_grant;
    logic                  owner_valid;
    logic                  xfer;
    logic                  release_burst;

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            lane_data[i] = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Scan from rr_ptr_q upward with explicit modulo wrap, so NUM_REQ need not be a power of two.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        scan_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            scan_idx = {1'b0, rr_ptr_q} + (TAG_W+1)'(i);
            if (scan_idx >= (TAG_W+1)'(NUM_REQ)) begin
                scan_idx = scan_idx - (TAG_W+1)'(NUM_REQ);
            end
            if (!pick_found && req_valid_i[scan_idx[TAG_W-1:0]]) begin
                pick_found = 1'b1;
                pick       = scan_idx[TAG_W-1:0];
            end
        end
    end

    assign owner_next_ptr = (owner_q == TAG_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
    assign in_grant       = (state_q == StGrant);
    assign owner_valid    = req_valid_i[owner_q];
    assign xfer           = rst_n_i && in_grant && owner_valid && !fifo_full_i;
    assign release_burst  = !owner_valid ||
                            (xfer && (req_last_i[owner_q] ||
                                      burst_cnt_q == CNT_W'(MAX_BURST - 1)));

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    owner_d     = pick;
                    burst_cnt_d = '0;
                    state_d     = StGrant;
                end
            end
            StGrant: begin
                if (release_burst) begin
                    state_d  = StIdle;
                    rr_ptr_d = owner_next_ptr;
                end else if (xfer) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready_o    = '0;
        grant_o        = '0;
        fifo_write_o   = xfer;
        fifo_wr_data_o = '0;
        fifo_wr_tag_o  = '0;
        busy_o         = rst_n_i && in_grant;
        if (in_grant) begin
            fifo_wr_data_o = lane_data[owner_q];
            fifo_wr_tag_o  = owner_q;
            if (rst_n_i) begin
                req_ready_o[owner_q] = !fifo_full_i;
                grant_o[owner_q]     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= StIdle;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

endmodule

// File: tb/tb_sync_fifo_rr_write_arbiter.sv
// Bench for sync_fifo_rr_write_arbiter: directed scenarios plus random traffic,
// every cycle compared against a transaction-level round-robin model.
module tb_sync_fifo_rr_write_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int MB = 8;
    localparam int TW = 2;
    localparam int VW = N + 1 + W + TW + N + 1;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           fifo_full;
    logic           fifo_write;
    logic [W-1:0]   fifo_wr_data;
    logic [TW-1:0]  fifo_wr_tag;
    logic [N-1:0]   grant;
    logic           busy;

    sync_fifo_rr_write_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (W),
        .MAX_BURST  (MB)
    ) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .req_valid_i    (req_valid),
        .req_data_i     (req_data),
        .req_last_i     (req_last),
        .req_ready_o    (req_ready),
        .fifo_full_i    (fifo_full),
        .fifo_write_o   (fifo_write),
        .fifo_wr_data_o (fifo_wr_data),
        .fifo_wr_tag_o  (fifo_wr_tag),
        .grant_o        (grant),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: owner index (-1 = nobody), next search start, words written in the current burst.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_cnt   = 0;

    logic [VW-1:0] exp_vec, obs_vec;
    logic [N-1:0]  obs_grant;
    logic          obs_busy, obs_write;
    logic [TW-1:0] obs_tag;
    logic [W-1:0]  log_data[$];
    logic [TW-1:0] log_tag[$];

    task automatic rand_data();
        for (int i = 0; i < N; i++) req_data[i*W +: W] = $urandom;
    endtask

    task automatic cycle();
        logic [N-1:0]  e_ready, e_grant;
        logic          e_write, e_busy;
        logic [W-1:0]  e_data;
        logic [TW-1:0] e_tag;
        @(negedge clk);
        e_ready = '0; e_grant = '0; e_write = 1'b0; e_busy = 1'b0; e_data = '0; e_tag = '0;
        if (m_owner >= 0) begin
            e_tag             = TW'(m_owner);
            e_data            = req_data[m_owner*W +: W];
            e_grant[m_owner]  = 1'b1;
            e_busy            = 1'b1;
            e_ready[m_owner]  = !fifo_full;
            e_write           = req_valid[m_owner] && !fifo_full;
        end
        if (!rst_n) begin
            e_ready = '0; e_grant = '0; e_write = 1'b0; e_busy = 1'b0;
        end
        exp_vec   = {e_ready, e_write, e_data, e_tag, e_grant, e_busy};
        obs_vec   = {req_ready, fifo_write, fifo_wr_data, fifo_wr_tag, grant, busy};
        obs_grant = grant;
        obs_busy  = busy;
        obs_write = fifo_write;
        obs_tag   = fifo_wr_tag;
        if (fifo_write === 1'b1) begin
            log_data.push_back(fifo_wr_data);
            log_tag.push_back(fifo_wr_tag);
        end
        if (!rst_n) begin
            m_owner = -1; m_ptr = 0; m_cnt = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                if (m_owner < 0 && req_valid[(m_ptr + k) % N]) begin
                    m_owner = (m_ptr + k) % N;
                    m_cnt   = 0;
                end
            end
        end else if (!req_valid[m_owner]) begin
            m_ptr = (m_owner + 1) % N; m_owner = -1;
        end else if (e_write) begin
            m_cnt++;
            if (req_last[m_owner] || m_cnt == MB) begin
                m_ptr = (m_owner + 1) % N; m_owner = -1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = N'($urandom); req_last = '0; fifo_full = 1'b0;
        for (int c = 0; c < 3; c++) begin
            rand_data();
            cycle();
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL reset_hold c%0d: got %h want %h", c, obs_vec, exp_vec);
            end
        end
        rst_n = 1'b1; req_valid = '0;
        for (int c = 0; c < 10; c++) begin
            rand_data();
            cycle();
            n_cmp++;
            if ({obs_grant, obs_busy, obs_write} !== '0 || obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL reset_idle c%0d: got %h want %h", c, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_round_robin();
        log_data.delete(); log_tag.delete();
        req_valid = '1; req_last = '0; fifo_full = 1'b0;
        for (int c = 0; c < 4 * (MB + 1); c++) begin
            rand_data();
            cycle();
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL rr c%0d: got %h want %h", c, obs_vec, exp_vec);
            end
        end
        n_cmp++;
        if (log_tag.size() != 4 * MB) begin
            n_fail++;
            $display("FAIL rr_count: got %0d want %0d", log_tag.size(), 4 * MB);
        end else begin
            for (int i = 0; i < 4 * MB; i++) begin
                n_cmp++;
                if (log_tag[i] !== TW'(i / MB)) begin
                    n_fail++;
                    $display("FAIL rr_tag[%0d]: got %0d want %0d", i, log_tag[i], i / MB);
                end
            end
        end
        req_valid = '0;
        cycle();
    endtask

    task automatic test_last();
        log_data.delete(); log_tag.delete();
        req_valid = 4'b0100; fifo_full = 1'b0;
        for (int c = 0; c < 20 && log_tag.size() < 3; c++) begin
            rand_data();
            req_data[2*W +: W] = 32'hA000_0000 + log_tag.size();
            req_last = (log_tag.size() == 2) ? 4'b0100 : 4'b0000;
            cycle();
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL last c%0d: got %h want %h", c, obs_vec, exp_vec);
            end
        end
        req_valid = '0; req_last = '0;
        n_cmp++;
        if (log_tag.size() != 3) begin
            n_fail++;
            $display("FAIL last_count: got %0d want 3", log_tag.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (log_tag[i] !== 2'd2 || log_data[i] !== 32'hA000_0000 + i) begin
                    n_fail++;
                    $display("FAIL last_word[%0d]: got tag %0d data %h want tag 2 data %h",
                             i, log_tag[i], log_data[i], 32'hA000_0000 + i);
                end
            end
        end
        cycle();
        req_valid = 4'b0010; req_last = 4'b0010;
        for (int c = 0; c < 2; c++) begin
            rand_data();
            cycle();
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL wrap c%0d: got %h want %h", c, obs_vec, exp_vec);
            end
        end
        n_cmp++;
        if (obs_grant !== 4'b0010) begin
            n_fail++;
            $display("FAIL wrap_grant: got %b want 0010", obs_grant);
        end
        req_valid = '0; req_last = '0;
        cycle();
    endtask

    task automatic test_backpressure();
        int stall = 0;
        log_data.delete(); log_tag.delete();
        req_valid = 4'b0010; req_last = '0; fifo_full = 1'b0;
        for (int c = 0; c < 40 && log_tag.size() < MB; c++) begin
            rand_data();
            req_data[1*W +: W] = 32'hB000_0000 + log_tag.size();
            if (log_tag.size() == 3 && stall < 5) begin
                fifo_full = 1'b1; stall++;
            end else begin
                fifo_full = 1'b0;
            end
            cycle();
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL bp c%0d full=%0d: got %h want %h", c, fifo_full, obs_vec, exp_vec);
            end
        end
        req_valid = '0; fifo_full = 1'b0;
        n_cmp++;
        if (log_tag.size() != MB || stall != 5) begin
            n_fail++;
            $display("FAIL bp_count: got %0d writes %0d stalls want %0d writes 5 stalls",
                     log_tag.size(), stall, MB);
        end else begin
            for (int i = 0; i < MB; i++) begin
                n_cmp++;
                if (log_tag[i] !== 2'd1 || log_data[i] !== 32'hB000_0000 + i) begin
                    n_fail++;
                    $display("FAIL bp_word[%0d]: got tag %0d data %h want tag 1 data %h",
                             i, log_tag[i], log_data[i], 32'hB000_0000 + i);
                end
            end
        end
        cycle();
    endtask

    task automatic test_drop();
        int  p0_writes = 0;
        int  drop_cyc  = -1;
        int  g3_cyc    = -1;
        logic seen_g0  = 1'b0;
        req_last = '0; fifo_full = 1'b0;
        for (int c = 0; c < 30 && g3_cyc < 0; c++) begin
            req_valid = '0;
            if (p0_writes < 2) req_valid[0] = 1'b1;
            else if (drop_cyc < 0) drop_cyc = c;
            if (seen_g0) req_valid[3] = 1'b1;
            rand_data();
            cycle();
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL drop c%0d: got %h want %h", c, obs_vec, exp_vec);
            end
            if (obs_grant === 4'b0001) seen_g0 = 1'b1;
            if (obs_write === 1'b1 && obs_tag === 2'd0) p0_writes++;
            if (obs_grant === 4'b1000) g3_cyc = c;
        end
        n_cmp++;
        if (p0_writes != 2 || g3_cyc < 0 || g3_cyc - drop_cyc != 2) begin
            n_fail++;
            $display("FAIL drop_release: got %0d writes, grant3 %0d cycles after drop; want 2, 2",
                     p0_writes, g3_cyc - drop_cyc);
        end
        req_valid = '0;
        cycle();
        cycle();
    endtask

    task automatic test_reset_mid();
        req_valid = '1; req_last = '0; fifo_full = 1'b0;
        for (int c = 0; c < 4; c++) begin
            rand_data();
            cycle();
        end
        rst_n = 1'b0;
        cycle();
        n_cmp++;
        if ({obs_write, obs_busy, obs_grant} !== '0 || obs_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL reset_mid: got %h want %h", obs_vec, exp_vec);
        end
        rst_n = 1'b1; req_valid = 4'b1010;
        for (int c = 0; c < 2; c++) begin
            rand_data();
            cycle();
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL post_reset c%0d: got %h want %h", c, obs_vec, exp_vec);
            end
        end
        n_cmp++;
        if (obs_grant !== 4'b0010) begin
            n_fail++;
            $display("FAIL post_reset_grant: got %b want 0010", obs_grant);
        end
        req_valid = '0;
        cycle();
        cycle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            req_valid = N'($urandom);
            req_last  = N'($urandom & $urandom);
            fifo_full = ($urandom_range(0, 4) == 0);
            rst_n     = ($urandom_range(0, 59) != 0);
            rand_data();
            cycle();
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL random c%0d: got %h want %h", c, obs_vec, exp_vec);
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = '0; req_last = '0; fifo_full = 1'b0; req_data = '0;
        test_reset();
        test_round_robin();
        test_last();
        test_backpressure();
        test_drop();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
